// File: rtl/dds_table_loader.sv
// dds_table_loader: streams a sine table from a valid/ready source into
// sequential DDS memory rows, then loads the start phase with a one-cycle
// set_phase strobe. Abandons the load if the source stalls for TIMEOUT cycles.
module dds_table_loader #(
   parameter int unsigned DATA_LEN    = 8,
   parameter int unsigned ROWS_BASE_2 = 9,
   parameter int unsigned PHASE_W     = 9,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic                   src_clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PHASE_W-1:0]     phase_cfg,
   input  logic [DATA_LEN-1:0]    in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_LEN-1:0]    data_wr,
   output logic [ROWS_BASE_2-1:0] addr_wr,
   output logic                   we,
   output logic                   set_phase,
   output logic [PHASE_W-1:0]     phase,
   output logic                   busy,
   output logic                   done,
   output logic                   err_timeout
);

   localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [ROWS_BASE_2-1:0] LAST_ROW = '1;
   localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SETPH = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ROWS_BASE_2-1:0] count;
   logic [TMO_W-1:0]       tcnt;
   logic [PHASE_W-1:0]     phase_lat;

   logic xfer;
   logic accept_start;
   logic sp_d;
   logic done_d;
   logic err_d;
   logic busy_d;

   // State register
   always_ff @(posedge src_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a transfer always beats the timeout terminal count
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            if (in_valid) begin
               if (count == LAST_ROW) state_nxt = S_SETPH;
            end else if (tcnt == TMO_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         S_SETPH: state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
      endcase
   end

   // Output decode: ready handshake plus next values of the registered strobes
   always_comb begin
      in_ready     = 1'b0;
      xfer         = 1'b0;
      accept_start = 1'b0;
      sp_d         = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      unique case (state)
         S_IDLE:  accept_start = start;
         S_LOAD: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            err_d    = !in_valid && (tcnt == TMO_LAST);
         end
         S_SETPH: sp_d   = 1'b1;
         S_FIN:   done_d = 1'b1;
      endcase
      // busy spans the load and the set_phase cycle, dropping as done rises
      busy_d = (state_nxt == S_LOAD) || (state_nxt == S_SETPH) || (state == S_SETPH);
   end

   // Registered outputs, row/idle counters and the latched start phase
   always_ff @(posedge src_clk) begin
      if (rst) begin
         we          <= 1'b0;
         set_phase   <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
         data_wr     <= '0;
         addr_wr     <= '0;
         phase       <= '0;
         phase_lat   <= '0;
         count       <= '0;
         tcnt        <= '0;
      end else begin
         we          <= xfer;
         set_phase   <= sp_d;
         done        <= done_d;
         err_timeout <= err_d;
         busy        <= busy_d;
         if (accept_start) begin
            phase_lat <= phase_cfg;
            count     <= '0;
            tcnt      <= '0;
         end
         if (xfer) begin
            data_wr <= in_data;
            addr_wr <= count;
            count   <= count + 1'b1;
            tcnt    <= '0;
         end else if (state == S_LOAD) begin
            tcnt <= tcnt + 1'b1;
         end
         if (sp_d) phase <= phase_lat;
      end
   end

endmodule
